// File: rtl/arty_dma_arbiter.sv
// Round-robin arbiter that shares one bsg_cache DMA channel (pkt / read data / write data)
// among num_req_p requesters. Optional watchdog enabled by defining ARTY_DMA_ARB_TIMEOUT_EN.
module arty_dma_arbiter #(
    parameter int unsigned num_req_p             = 2,
    parameter int unsigned addr_width_p          = 28,
    parameter int unsigned data_width_p          = 64,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned timeout_cycles_p      = 4096
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_req_p*(addr_width_p+1)-1:0]    req_dma_pkt_i,
    input  logic [num_req_p-1:0]                     req_dma_pkt_v_i,
    output logic [num_req_p-1:0]                     req_dma_pkt_yumi_o,
    output logic [data_width_p-1:0]                  req_dma_data_o,
    output logic [num_req_p-1:0]                     req_dma_data_v_o,
    input  logic [num_req_p-1:0]                     req_dma_data_ready_and_i,
    input  logic [num_req_p*data_width_p-1:0]        req_dma_data_i,
    input  logic [num_req_p-1:0]                     req_dma_data_v_i,
    output logic [num_req_p-1:0]                     req_dma_data_yumi_o,
    output logic [addr_width_p:0]                    dma_pkt_o,
    output logic                                     dma_pkt_v_o,
    input  logic                                     dma_pkt_yumi_i,
    input  logic [data_width_p-1:0]                  dma_data_i,
    input  logic                                     dma_data_v_i,
    output logic                                     dma_data_ready_and_o,
    output logic [data_width_p-1:0]                  dma_data_o,
    output logic                                     dma_data_v_o,
    input  logic                                     dma_data_yumi_i,
    output logic [$clog2(num_req_p)-1:0]             grant_id_o,
    output logic                                     busy_o,
    output logic                                     error_o
);
    localparam int unsigned PKT_W = addr_width_p + 1;
    localparam int unsigned ID_W  = $clog2(num_req_p);
    localparam int unsigned CNT_W = $clog2(block_size_in_words_p) + 1;
    localparam int unsigned TO_W  = $clog2(timeout_cycles_p + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(block_size_in_words_p - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(num_req_p - 1);

    typedef enum logic [1:0] {IDLE, PKT, RDATA, WDATA} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d, rr_q, rr_d, win_id, next_rr;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              win_found, pkt_hs, rd_hs, wr_hs, last_beat;
    logic [PKT_W-1:0]  sel_pkt;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int unsigned ofs);
        return ID_W'((32'(base) + ofs) % num_req_p);
    endfunction

    // First pending requester at or above the rr pointer, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_q;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (!win_found && req_dma_pkt_v_i[rr_idx(rr_q, i)]) begin
                win_found = 1'b1;
                win_id    = rr_idx(rr_q, i);
            end
        end
    end

    assign sel_pkt   = req_dma_pkt_i[32'(grant_q)*PKT_W +: PKT_W];
    assign pkt_hs    = (state_q == PKT) && dma_pkt_yumi_i;
    assign rd_hs     = (state_q == RDATA) && dma_data_v_i && req_dma_data_ready_and_i[grant_q];
    assign wr_hs     = (state_q == WDATA) && dma_data_yumi_i;
    assign last_beat = (beat_q == LAST_BEAT);
    assign next_rr   = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);

`ifdef ARTY_DMA_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles_p - 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        rr_d                 = rr_q;
        beat_d               = beat_q;
        req_dma_pkt_yumi_o   = '0;
        req_dma_data_v_o     = '0;
        req_dma_data_yumi_o  = '0;
        dma_pkt_v_o          = 1'b0;
        dma_data_ready_and_o = 1'b0;
        dma_data_v_o         = 1'b0;
        dma_pkt_o            = sel_pkt;
        dma_data_o           = req_dma_data_i[32'(grant_q)*data_width_p +: data_width_p];
        req_dma_data_o       = dma_data_i;
`ifdef ARTY_DMA_ARB_TIMEOUT_EN
        to_d                 = to_q;
        err_d                = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_id;
                    state_d = PKT;
                end
            end
            PKT: begin
                dma_pkt_v_o                 = req_dma_pkt_v_i[grant_q];
                req_dma_pkt_yumi_o[grant_q] = dma_pkt_yumi_i;
                if (pkt_hs) begin
                    beat_d  = '0;
                    state_d = sel_pkt[PKT_W-1] ? WDATA : RDATA;
                end
            end
            RDATA: begin
                dma_data_ready_and_o      = req_dma_data_ready_and_i[grant_q];
                req_dma_data_v_o[grant_q] = dma_data_v_i;
                if (rd_hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                        rr_d    = next_rr;
                    end
                end
            end
            WDATA: begin
                dma_data_v_o                 = req_dma_data_v_i[grant_q];
                req_dma_data_yumi_o[grant_q] = dma_data_yumi_i;
                if (wr_hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                        rr_d    = next_rr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef ARTY_DMA_ARB_TIMEOUT_EN
        // Watchdog: counts consecutive cycles without a handshake while a grant is held.
        if (state_q == IDLE || pkt_hs || rd_hs || wr_hs) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            to_d    = '0;
            err_d   = 1'b1;
            state_d = IDLE;
            rr_d    = next_rr;
        end else begin
            to_d = to_q + TO_W'(1);
        end
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

`ifdef ARTY_DMA_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign error_o = err_q;
`else
    logic [TO_W-1:0] unused_timeout;
    assign unused_timeout = TO_W'(timeout_cycles_p);
    assign error_o        = 1'b0;
`endif

    assign grant_id_o = grant_q;
    assign busy_o     = (state_q != IDLE);

`ifndef SYNTHESIS
    // A granted requester must keep its packet valid until the downstream consumes it.
    hold_pkt_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_q == PKT) |-> req_dma_pkt_v_i[grant_q])
        else $error("requester %0d dropped pkt_v before yumi", grant_q);
`endif

endmodule
